// File: rtl/uart_pkg.sv
// uart_pkg: register map, LSR bit positions, IIR codes and serial FSM states shared by the UART.
package uart_pkg;

    localparam logic [2:0] REG_RBR_THR = 3'd0;
    localparam logic [2:0] REG_IER     = 3'd1;
    localparam logic [2:0] REG_IIR_FCR = 3'd2;
    localparam logic [2:0] REG_LCR     = 3'd3;
    localparam logic [2:0] REG_MCR     = 3'd4;
    localparam logic [2:0] REG_LSR     = 3'd5;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_FE   = 3;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;

    localparam logic [7:0] IIR_LINE = 8'h06;
    localparam logic [7:0] IIR_RXDA = 8'h04;
    localparam logic [7:0] IIR_THRE = 8'h02;
    localparam logic [7:0] IIR_NONE = 8'h01;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
        return w[8*lane +: 8];
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with flush; an empty FIFO forwards wdata so push+pop passes through.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & (~empty_o | push_i);
    assign rdata_o = empty_o ? wdata_i : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_controller.sv
// uart_fifo_controller: 16550-style 8N1 UART (16x oversampling) with divisor, FIFOs, LSR and level irq.
// Define UART_LOOPBACK_EN to add MCR at offset 4; MCR[4] loops TX into RX and holds uart_tx high.
module uart_fifo_controller
    import uart_pkg::*;
#(
    parameter int          RX_DEPTH    = 16,
    parameter int          TX_DEPTH    = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ren,
    input  logic        wen,
    input  logic [2:0]  address,
    input  logic [31:0] word_in,
    output logic [31:0] data_out,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    logic [7:0]  wbyte, rd_byte, lsr, iir;
    logic [7:0]  lcr_q, dll_q, dlm_q;
    logic [2:0]  ier_q;
    logic [31:0] data_out_q;
    logic        dlab, wr_thr, wr_dll, wr_dlm, wr_ier, wr_fcr, wr_lcr, rd_rbr, rd_lsr;
    logic        oe_q, fe_q, oe_d, fe_d, irq_q, irq_d;

    logic [7:0]  tx_rdata, rx_rdata;
    logic        tx_full, tx_empty, rx_full, rx_empty, tx_load, rx_pop, rx_done, rx_in;

    logic [15:0] div, reload, baud_cnt_q;
    logic        tick;

    tx_state_e   tx_state_q;
    logic [7:0]  tx_shift_q;
    logic [3:0]  tx_tick_q;
    logic [2:0]  tx_bit_q;
    logic        tx_out_q;

    rx_state_e   rx_state_q;
    logic [7:0]  rx_shift_q;
    logic [3:0]  rx_tick_q;
    logic [2:0]  rx_bit_q;
    logic        rx_s1_q, rx_s2_q;

    assign wbyte  = lane_byte(word_in, address[1:0]);
    assign dlab   = lcr_q[7];
    assign wr_thr = wen & (address == REG_RBR_THR) & ~dlab;
    assign wr_dll = wen & (address == REG_RBR_THR) & dlab;
    assign wr_ier = wen & (address == REG_IER) & ~dlab;
    assign wr_dlm = wen & (address == REG_IER) & dlab;
    assign wr_fcr = wen & (address == REG_IIR_FCR);
    assign wr_lcr = wen & (address == REG_LCR);
    assign rd_rbr = ren & (address == REG_RBR_THR) & ~dlab;
    assign rd_lsr = ren & (address == REG_LSR);

`ifdef UART_LOOPBACK_EN
    logic [4:0] mcr_q;
    logic       wr_mcr;
    assign wr_mcr  = wen & (address == REG_MCR);
    assign rx_in   = mcr_q[4] ? tx_out_q : uart_rx;
    assign uart_tx = mcr_q[4] | tx_out_q;

    always_ff @(posedge clk) begin
        if (reset)       mcr_q <= '0;
        else if (wr_mcr) mcr_q <= wbyte[4:0];
    end
`else
    assign rx_in   = uart_rx;
    assign uart_tx = tx_out_q;
`endif

    assign data_out = data_out_q;
    assign irq      = irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ier_q <= '0;
            lcr_q <= '0;
            dll_q <= DEFAULT_DIV[7:0];
            dlm_q <= DEFAULT_DIV[15:8];
        end else begin
            if (wr_ier) ier_q <= wbyte[2:0];
            if (wr_lcr) lcr_q <= wbyte;
            if (wr_dll) dll_q <= wbyte;
            if (wr_dlm) dlm_q <= wbyte;
        end
    end

    // Up-counter so a divisor write only needs to clear it; >= covers a shrink below the count.
    assign div    = {dlm_q, dll_q};
    assign reload = (div == 16'd0) ? 16'd0 : div - 16'd1;
    assign tick   = (baud_cnt_q >= reload);

    always_ff @(posedge clk) begin
        if (reset || wr_dll || wr_dlm) baud_cnt_q <= '0;
        else if (tick)                 baud_cnt_q <= '0;
        else                           baud_cnt_q <= baud_cnt_q + 16'd1;
    end

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_thr & ~tx_full),
        .wdata_i (wbyte),
        .pop_i   (tx_load),
        .flush_i (wr_fcr & wbyte[2]),
        .rdata_o (tx_rdata),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    assign rx_pop = rd_rbr & ~rx_empty;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_done),
        .wdata_i (rx_shift_q),
        .pop_i   (rx_pop),
        .flush_i (wr_fcr & wbyte[1]),
        .rdata_o (rx_rdata),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // Load from IDLE, or straight from the end of STOP so back-to-back frames have no gap.
    assign tx_load = ~tx_empty & ((tx_state_q == TX_IDLE) |
                     ((tx_state_q == TX_STOP) & tick & (tx_tick_q == 4'd15)));

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_out_q   <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: if (tx_load) begin
                    tx_shift_q <= tx_rdata;
                    tx_tick_q  <= '0;
                    tx_out_q   <= 1'b0;
                    tx_state_q <= TX_START;
                end
                TX_START: if (tick) begin
                    tx_tick_q <= tx_tick_q + 4'd1;
                    if (tx_tick_q == 4'd15) begin
                        tx_out_q   <= tx_shift_q[0];
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: if (tick) begin
                    tx_tick_q <= tx_tick_q + 4'd1;
                    if (tx_tick_q == 4'd15) begin
                        if (tx_bit_q == 3'd7) begin
                            tx_out_q   <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_out_q   <= tx_shift_q[1];
                            tx_bit_q   <= tx_bit_q + 3'd1;
                        end
                    end
                end
                TX_STOP: if (tick) begin
                    tx_tick_q <= tx_tick_q + 4'd1;
                    if (tx_tick_q == 4'd15) begin
                        if (tx_load) begin
                            tx_shift_q <= tx_rdata;
                            tx_out_q   <= 1'b0;
                            tx_state_q <= TX_START;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx_in;
            rx_s2_q <= rx_s1_q;
        end
    end

    assign rx_done = (rx_state_q == RX_STOP) & tick & (rx_tick_q == 4'd15);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: if (!rx_s2_q) begin
                    rx_tick_q  <= '0;
                    rx_state_q <= RX_START;
                end
                // The 8th tick is mid-start; after that every 16th tick lands mid-bit.
                RX_START: if (tick) begin
                    rx_tick_q <= rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd7) begin
                        rx_tick_q  <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: if (tick) begin
                    rx_tick_q <= rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd15) begin
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end
                end
                RX_STOP: if (tick) begin
                    rx_tick_q <= rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd15) rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // A fresh error outranks the clear-on-read of the same cycle.
    assign oe_d = (rx_done & rx_full & ~rx_pop) | (oe_q & ~rd_lsr);
    assign fe_d = (rx_done & ~rx_s2_q) | (fe_q & ~rd_lsr);

    always_comb begin
        lsr           = 8'h00;
        lsr[LSR_DR]   = ~rx_empty;
        lsr[LSR_OE]   = oe_q;
        lsr[LSR_FE]   = fe_q;
        lsr[LSR_THRE] = tx_empty;
        lsr[LSR_TEMT] = tx_empty & (tx_state_q == TX_IDLE);
    end

    always_comb begin
        if (ier_q[2] & (oe_q | fe_q)) iir = IIR_LINE;
        else if (ier_q[0] & ~rx_empty) iir = IIR_RXDA;
        else if (ier_q[1] & tx_empty)  iir = IIR_THRE;
        else                           iir = IIR_NONE;
    end

    assign irq_d = (ier_q[0] & ~rx_empty) | (ier_q[1] & tx_empty) | (ier_q[2] & (oe_q | fe_q));

    always_comb begin
        rd_byte = 8'h00;
        case (address)
            REG_RBR_THR: rd_byte = dlab ? dll_q : (rx_empty ? 8'h00 : rx_rdata);
            REG_IER:     rd_byte = dlab ? dlm_q : {5'b0, ier_q};
            REG_IIR_FCR: rd_byte = iir;
            REG_LCR:     rd_byte = lcr_q;
`ifdef UART_LOOPBACK_EN
            REG_MCR:     rd_byte = {3'b0, mcr_q};
`endif
            REG_LSR:     rd_byte = lsr;
            default:     rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
            oe_q       <= 1'b0;
            fe_q       <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (ren) data_out_q <= {4{rd_byte}};
            oe_q  <= oe_d;
            fe_q  <= fe_d;
            irq_q <= irq_d;
        end
    end

endmodule

// File: tb/tb_uart_fifo_controller.sv
// Directed bench for uart_fifo_controller: register map, TX/RX framing, FIFO limits, errors and irq.
module tb_uart_fifo_controller;

    localparam int BIT_CLK  = 32;
    localparam int TX_DEPTH = 16;
    localparam int RX_DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset, ren, wen, uart_rx, uart_tx, irq;
    logic [2:0]  address;
    logic [31:0] word_in, data_out;

    int          vectors = 0;
    int          miscompares = 0;
    int          low_cnt = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  tx_q[$];
    logic        stop_q[$];

    always #5 clk = ~clk;

    uart_fifo_controller #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH), .DEFAULT_DIV(16'd15)) dut (
        .clk      (clk),
        .reset    (reset),
        .ren      (ren),
        .wen      (wen),
        .address  (address),
        .word_in  (word_in),
        .data_out (data_out),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .irq      (irq)
    );

    always @(negedge clk) if (uart_tx !== 1'b1) low_cnt++;

    // Serial decoder on uart_tx, sampling mid-bit at the programmed 32-clock bit time.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && uart_tx === 1'b0) begin
                repeat (BIT_CLK/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CLK) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (BIT_CLK) @(negedge clk);
                tx_q.push_back(b);
                stop_q.push_back(uart_tx);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] b);
        @(negedge clk);
        wen = 1'b1; address = a; word_in = 32'(b) << (8*a[1:0]);
        @(negedge clk);
        wen = 1'b0; word_in = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] v);
        @(negedge clk);
        ren = 1'b1; address = a;
        @(negedge clk);
        ren = 1'b0;
        v = data_out[7:0];
    endtask

    task automatic rdchk(input string tag, input logic [2:0] a, input logic [7:0] e);
        @(negedge clk);
        ren = 1'b1; address = a;
        @(negedge clk);
        ren = 1'b0;
        chk(tag, data_out, {4{e}});
    endtask

    task automatic wait_lsr(input string tag, input logic [7:0] mask, input logic [7:0] val, input int budget);
        logic [7:0] v;
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            rd(3'd5, v);
            if ((v & mask) == val) ok = 1'b1;
            else repeat (16) @(negedge clk);
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_ok);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        uart_rx = stop_ok;
        // A bad stop is released early so the follow-on false start resolves high.
        repeat (stop_ok ? BIT_CLK : 26) @(negedge clk);
        uart_rx = 1'b1;
        repeat (BIT_CLK + 4) @(negedge clk);
    endtask

    initial begin
        int snap;
        reset = 1'b1; ren = 1'b0; wen = 1'b0; address = '0; word_in = '0; uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rdchk("rst_lsr", 3'd5, 8'h60);
        rdchk("rst_iir", 3'd2, 8'h01);

        wr(3'd3, 8'h80);
        rdchk("rst_dll", 3'd0, 8'h0F);
        rdchk("rst_dlm", 3'd1, 8'h00);
        wr(3'd0, 8'h02);
        wr(3'd1, 8'h00);
        wr(3'd3, 8'h03);
        rdchk("lcr", 3'd3, 8'h03);

        mon_en = 1'b1;
        tx_q.delete(); stop_q.delete();
        wr(3'd0, 8'h55);
        repeat (50) @(negedge clk);
        rdchk("lsr_tx_busy", 3'd5, 8'h20);
        wait_lsr("tx1_temt", 8'h40, 8'h40, 100);
        chk("tx1_count", tx_q.size(), 1);
        chk("tx1_byte", (tx_q.size() > 0) ? tx_q[0] : 8'hxx, 8'h55);
        chk("tx1_stop", (stop_q.size() > 0) ? stop_q[0] : 1'bx, 1'b1);

        tx_q.delete(); stop_q.delete();
        for (int i = 0; i < TX_DEPTH + 2; i++) begin
            @(negedge clk);
            wen = 1'b1; address = 3'd0; word_in = 32'h10 + i;
        end
        @(negedge clk);
        wen = 1'b0; word_in = '0;
        wait_lsr("burst_temt", 8'h40, 8'h40, 600);
        chk("burst_count", tx_q.size(), TX_DEPTH + 1);
        for (int i = 0; i < TX_DEPTH + 1; i++)
            chk($sformatf("burst_byte%0d", i), (i < tx_q.size()) ? tx_q[i] : 8'hxx, 8'h10 + i);

        wr(3'd1, 8'h02);
        @(negedge clk);
        chk("thre_irq", {31'd0, irq}, 32'd1);
        rdchk("thre_iir", 3'd2, 8'h02);

        wr(3'd1, 8'h01);
        @(negedge clk);
        chk("rx_irq_idle", {31'd0, irq}, 32'd0);
        send_rx(8'hA5, 1'b1);
        chk("rx_irq_set", {31'd0, irq}, 32'd1);
        rdchk("rx_lsr_dr", 3'd5, 8'h61);
        rdchk("rx_iir", 3'd2, 8'h04);
        rdchk("rx_rbr", 3'd0, 8'hA5);
        rdchk("rx_lsr_empty", 3'd5, 8'h60);
        chk("rx_irq_clr", {31'd0, irq}, 32'd0);

        wr(3'd1, 8'h00);
        for (int i = 0; i < RX_DEPTH + 1; i++) send_rx(8'h30 + 8'(i), 1'b1);
        rdchk("ovr_lsr", 3'd5, 8'h63);
        rdchk("ovr_lsr_clr", 3'd5, 8'h61);
        for (int i = 0; i < RX_DEPTH; i++)
            rdchk($sformatf("ovr_rbr%0d", i), 3'd0, 8'h30 + 8'(i));
        rdchk("rbr_empty", 3'd0, 8'h00);
        rdchk("ovr_lsr_end", 3'd5, 8'h60);

        wr(3'd1, 8'h04);
        send_rx(8'h81, 1'b0);
        rdchk("fe_iir", 3'd2, 8'h06);
        chk("fe_irq", {31'd0, irq}, 32'd1);
        rdchk("fe_lsr", 3'd5, 8'h69);
        rdchk("fe_lsr_clr", 3'd5, 8'h61);
        rdchk("fe_rbr", 3'd0, 8'h81);
        chk("fe_irq_clr", {31'd0, irq}, 32'd0);
        wr(3'd1, 8'h00);

`ifdef UART_LOOPBACK_EN
        snap = low_cnt;
        wr(3'd4, 8'h10);
        rdchk("mcr", 3'd4, 8'h10);
        wr(3'd0, 8'h3C);
        wait_lsr("lb_dr", 8'h01, 8'h01, 100);
        chk("lb_tx_high", low_cnt - snap, 0);
        rdchk("lb_rbr", 3'd0, 8'h3C);
        wait_lsr("lb_temt", 8'h40, 8'h40, 100);
        wr(3'd4, 8'h00);
`else
        snap = low_cnt;
        wr(3'd4, 8'h10);
        rdchk("off4_unmapped", 3'd4, 8'h00);
        chk("off4_tx_idle", low_cnt - snap, 0);
`endif
        wr(3'd7, 8'hFF);
        rdchk("off7_unmapped", 3'd7, 8'h00);
        rdchk("off6_unmapped", 3'd6, 8'h00);

        mon_en = 1'b0;
        wr(3'd1, 8'h02);
        wr(3'd0, 8'h00);
        repeat (100) @(negedge clk);
        chk("mid_tx_low", {31'd0, uart_tx}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        chk("mid_rst_data", data_out, 32'h0);
        rdchk("mid_rst_lsr", 3'd5, 8'h60);
        rdchk("mid_rst_iir", 3'd2, 8'h01);
        rdchk("mid_rst_ier", 3'd1, 8'h00);
        wr(3'd3, 8'h80);
        rdchk("mid_rst_dll", 3'd0, 8'h0F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
